// File: rtl/rvfi_dmem_window_check_pkg.sv
// Shared types and helpers for the RVFI data-memory window checks.
// Helpers work on the widest supported XLEN so every checker width can share them.
package rvfi_check_pkg;

    localparam int unsigned MAX_XLEN = 64;
    localparam int unsigned MAX_XB   = MAX_XLEN / 8;

    typedef logic [MAX_XB-1:0]   byte_mask_t;
    typedef logic [MAX_XLEN-1:0] wide_addr_t;

    function automatic int unsigned xb_of(input int unsigned xlen);
        return xlen / 8;
    endfunction

    // Locator outputs carry one spare bit so a single-entry dimension still has width.
    function automatic int unsigned idx_w(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

    // Window match is computed modulo 2^xlen so a window may wrap past the top of memory.
    function automatic logic word_hit(input wide_addr_t  addr,
                                      input wide_addr_t  base,
                                      input int unsigned k,
                                      input int unsigned xlen);
        wide_addr_t mask;
        wide_addr_t diff;
        mask = (xlen >= MAX_XLEN) ? '1 : ((MAX_XLEN'(1) << xlen) - MAX_XLEN'(1));
        diff = (addr - base) & mask;
        return diff == (MAX_XLEN'(k) * MAX_XLEN'(xlen / 8));
    endfunction

    function automatic logic addr_in_range(input wide_addr_t addr,
                                           input wide_addr_t lo,
                                           input wide_addr_t hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/rvfi_dmem_window_check_if.sv
// RVFI memory-access slice consumed by the data-memory window checker.
interface rvfi_dmem_window_check_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NRET = 1
);
    localparam int unsigned XB = XLEN / 8;

    logic [NRET-1:0]      rvfi_valid;
    logic [NRET*XLEN-1:0] rvfi_mem_addr;
    logic [NRET*XB-1:0]   rvfi_mem_rmask;
    logic [NRET*XB-1:0]   rvfi_mem_wmask;
    logic [NRET*XLEN-1:0] rvfi_mem_rdata;
    logic [NRET*XLEN-1:0] rvfi_mem_wdata;

    modport master (
        output rvfi_valid, rvfi_mem_addr, rvfi_mem_rmask,
               rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata
    );

    modport slave (
        input rvfi_valid, rvfi_mem_addr, rvfi_mem_rmask,
              rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata
    );
endinterface

// File: rtl/rvfi_dmem_window_check_shadow.sv
// One shadow word of the checked window: XLEN data bits plus a written bit per byte.
// Channel c sees the word as left by channels 0..c-1 of the same cycle.
module rvfi_dmem_shadow_word #(
    parameter  int unsigned XLEN = 32,
    parameter  int unsigned NRET = 1,
    localparam int unsigned XB   = XLEN / 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NRET-1:0][XB-1:0]   wen_i,
    input  logic [NRET-1:0][XLEN-1:0] wdata_i,
    output logic [NRET-1:0][XLEN-1:0] view_data_o,
    output logic [NRET-1:0][XB-1:0]   view_written_o
);

    logic [XLEN-1:0] data_q, data_d;
    logic [XB-1:0]   written_q, written_d;

    // NOTE: every output of this block gets a value before any condition, so no latch is inferred.
    always_comb begin
        data_d    = data_q;
        written_d = written_q;
        for (int c = 0; c < NRET; c++) begin
            view_data_o[c]    = data_d;
            view_written_o[c] = written_d;
            for (int b = 0; b < XB; b++) begin
                if (wen_i[c][b]) begin
                    data_d[b*8 +: 8] = wdata_i[c][b*8 +: 8];
                    written_d[b]     = 1'b1;
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so all registers sample the same edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            written_q <= '0;
        end else begin
            written_q <= written_d;
        end
    end

    // NOTE: data bytes are only ever read where written_q is set, so they carry no reset.
    always_ff @(posedge clock) begin
        data_q <= data_d;
    end

endmodule

// File: rtl/rvfi_dmem_window_check.sv
// Data-memory consistency check over NWORDS words at base_addr: each read byte must
// equal the last value written there. Reports a sticky error, first-error locator and a check count.
module rvfi_dmem_window_check
    import rvfi_check_pkg::*;
#(
    parameter  int unsigned     XLEN      = 32,
    parameter  int unsigned     NRET      = 1,
    parameter  int unsigned     NWORDS    = 4,
    parameter  int unsigned     CNTW      = 16,
    parameter  logic [XLEN-1:0] BASE_SEED = '0,
    parameter  logic [XLEN-1:0] VALID_LO  = '0,
    parameter  logic [XLEN-1:0] VALID_HI  = '1,
    localparam int unsigned     XB        = XLEN / 8,
    localparam int unsigned     CH_W      = idx_w(NRET),
    localparam int unsigned     WD_W      = idx_w(NWORDS),
    localparam int unsigned     BY_W      = idx_w(XB)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    output logic [XLEN-1:0]         base_addr,
    rvfi_dmem_window_check_if.slave rvfi,
    output logic                    dmem_err,
    output logic [CH_W-1:0]         err_channel,
    output logic [WD_W-1:0]         err_word,
    output logic [BY_W-1:0]         err_byte,
    output logic [CNTW-1:0]         check_count
);

    localparam int unsigned     INC_W   = $clog2(NRET + 1);
    localparam int unsigned     SUM_W   = CNTW + INC_W;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [NWORDS-1:0]              word_sel     [NRET];
    logic [NRET-1:0][XB-1:0]        word_wen     [NWORDS];
    logic [NRET-1:0][XLEN-1:0]      view_data    [NWORDS];
    logic [NRET-1:0][XB-1:0]        view_written [NWORDS];

    logic                           hit_found;
    logic [CH_W-1:0]                hit_channel;
    logic [WD_W-1:0]                hit_word;
    logic [BY_W-1:0]                hit_byte;
    logic [NRET-1:0]                chan_cmp;
    logic [INC_W-1:0]               n_checked;

    logic                           err_q;
    logic [CH_W-1:0]                err_channel_q;
    logic [WD_W-1:0]                err_word_q;
    logic [BY_W-1:0]                err_byte_q;
    logic [CNTW-1:0]                count_q, count_d;
    logic [SUM_W-1:0]               count_sum;

    assign base_addr = BASE_SEED & ~XLEN'(XB - 1);

    // Routing depends only on the bus, keeping it apart from the compare that reads the shadow views.
    always_comb begin
        for (int c = 0; c < NRET; c++) begin
            word_sel[c] = '0;
            if (rvfi.rvfi_valid[c]
                && ((rvfi.rvfi_mem_addr[c*XLEN +: XLEN] & XLEN'(XB - 1)) == '0)
                && addr_in_range(MAX_XLEN'(rvfi.rvfi_mem_addr[c*XLEN +: XLEN]),
                                 MAX_XLEN'(VALID_LO), MAX_XLEN'(VALID_HI))) begin
                for (int k = 0; k < NWORDS; k++) begin
                    word_sel[c][k] = word_hit(MAX_XLEN'(rvfi.rvfi_mem_addr[c*XLEN +: XLEN]),
                                              MAX_XLEN'(base_addr), k, XLEN);
                end
            end
        end
        for (int k = 0; k < NWORDS; k++) begin
            for (int c = 0; c < NRET; c++) begin
                word_wen[k][c] = word_sel[c][k] ? rvfi.rvfi_mem_wmask[c*XB +: XB] : '0;
            end
        end
    end

    for (genvar k = 0; k < NWORDS; k++) begin : g_word
        rvfi_dmem_shadow_word #(
            .XLEN (XLEN),
            .NRET (NRET)
        ) u_word (
            .clock          (clock),
            .reset          (reset),
            .wen_i          (word_wen[k]),
            .wdata_i        (rvfi.rvfi_mem_wdata),
            .view_data_o    (view_data[k]),
            .view_written_o (view_written[k])
        );
    end

    // Ascending scan with a found flag yields channel, then word, then byte priority.
    always_comb begin
        hit_found   = 1'b0;
        hit_channel = '0;
        hit_word    = '0;
        hit_byte    = '0;
        chan_cmp    = '0;
        n_checked   = '0;
        for (int c = 0; c < NRET; c++) begin
            for (int k = 0; k < NWORDS; k++) begin
                for (int b = 0; b < XB; b++) begin
                    if (word_sel[c][k] && enable && rvfi.rvfi_mem_rmask[c*XB + b]
                        && view_written[k][c][b]) begin
                        chan_cmp[c] = 1'b1;
                        if (!hit_found
                            && (rvfi.rvfi_mem_rdata[c*XLEN + b*8 +: 8] != view_data[k][c][b*8 +: 8])) begin
                            hit_found   = 1'b1;
                            hit_channel = CH_W'(c);
                            hit_word    = WD_W'(k);
                            hit_byte    = BY_W'(b);
                        end
                    end
                end
            end
            if (chan_cmp[c]) begin
                n_checked = n_checked + INC_W'(1);
            end
        end
    end

    assign count_sum = SUM_W'(count_q) + SUM_W'(n_checked);
    assign count_d   = (count_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : count_sum[CNTW-1:0];

    always_ff @(posedge clock) begin
        if (!reset) begin
            err_q         <= 1'b0;
            err_channel_q <= '0;
            err_word_q    <= '0;
            err_byte_q    <= '0;
            count_q       <= '0;
        end else begin
            if (hit_found && !err_q) begin
                err_q         <= 1'b1;
                err_channel_q <= hit_channel;
                err_word_q    <= hit_word;
                err_byte_q    <= hit_byte;
            end
            count_q <= count_d;
        end
    end

    assign dmem_err    = err_q;
    assign err_channel = err_channel_q;
    assign err_word    = err_word_q;
    assign err_byte    = err_byte_q;
    assign check_count = count_q;

`ifdef FORMAL
    always_comb begin
        if (reset) begin
            assert (!hit_found);
        end
    end
`endif

endmodule

// File: tb/tb_rvfi_dmem_window_check.sv
// Directed bench: dut_a windows 0x1000, dut_b windows 0xFFFFFFF8 (wrapping); both share one RVFI bus.
module tb_rvfi_dmem_window_check;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NRET   = 2;
    localparam int unsigned NWORDS = 4;
    localparam int unsigned CNTW   = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b1;

    always #5 clock = ~clock;

    rvfi_dmem_window_check_if #(.XLEN(XLEN), .NRET(NRET)) rif ();

    logic [31:0] base_a, base_b;
    logic        err_a, err_b;
    logic [1:0]  ch_a, ch_b;
    logic [2:0]  wd_a, wd_b;
    logic [2:0]  by_a, by_b;
    logic [15:0] cnt_a, cnt_b;

    rvfi_dmem_window_check #(
        .XLEN(XLEN), .NRET(NRET), .NWORDS(NWORDS), .CNTW(CNTW), .BASE_SEED(32'h0000_1003)
    ) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .base_addr(base_a), .rvfi(rif),
        .dmem_err(err_a), .err_channel(ch_a), .err_word(wd_a), .err_byte(by_a), .check_count(cnt_a)
    );

    rvfi_dmem_window_check #(
        .XLEN(XLEN), .NRET(NRET), .NWORDS(NWORDS), .CNTW(CNTW), .BASE_SEED(32'hFFFF_FFFB)
    ) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .base_addr(base_b), .rvfi(rif),
        .dmem_err(err_b), .err_channel(ch_b), .err_word(wd_b), .err_byte(by_b), .check_count(cnt_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        rif.rvfi_valid     = '0;
        rif.rvfi_mem_addr  = '0;
        rif.rvfi_mem_rmask = '0;
        rif.rvfi_mem_wmask = '0;
        rif.rvfi_mem_rdata = '0;
        rif.rvfi_mem_wdata = '0;
    endtask

    task automatic drive(input int c, input logic [31:0] addr, input logic [3:0] rmask,
                         input logic [3:0] wmask, input logic [31:0] rdata, input logic [31:0] wdata);
        rif.rvfi_valid[c]            = 1'b1;
        rif.rvfi_mem_addr[c*32 +: 32] = addr;
        rif.rvfi_mem_rmask[c*4 +: 4]  = rmask;
        rif.rvfi_mem_wmask[c*4 +: 4]  = wmask;
        rif.rvfi_mem_rdata[c*32 +: 32] = rdata;
        rif.rvfi_mem_wdata[c*32 +: 32] = wdata;
    endtask

    // One retire on a single channel for one clock, bus idle afterwards.
    task automatic op(input int c, input logic [31:0] addr, input logic [3:0] rmask,
                      input logic [3:0] wmask, input logic [31:0] rdata, input logic [31:0] wdata);
        idle();
        drive(c, addr, rmask, wmask, rdata, wdata);
        step();
        idle();
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (err_a !== 1'b0)   begin n_fail++; $display("FAIL reset_err: got %0h want 0", err_a); end
        n_checks++; if (ch_a !== 2'd0)    begin n_fail++; $display("FAIL reset_ch: got %0h want 0", ch_a); end
        n_checks++; if (wd_a !== 3'd0)    begin n_fail++; $display("FAIL reset_word: got %0h want 0", wd_a); end
        n_checks++; if (by_a !== 3'd0)    begin n_fail++; $display("FAIL reset_byte: got %0h want 0", by_a); end
        n_checks++; if (cnt_a !== 16'd0)  begin n_fail++; $display("FAIL reset_count: got %0h want 0", cnt_a); end
        n_checks++; if (err_b !== 1'b0)   begin n_fail++; $display("FAIL reset_err_b: got %0h want 0", err_b); end
        n_checks++; if (base_a !== 32'h0000_1000) begin n_fail++; $display("FAIL base_a: got %h want 00001000", base_a); end
        n_checks++; if (base_b !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL base_b: got %h want fffffff8", base_b); end
    endtask

    task automatic test_write_read();
        do_reset();
        op(0, 32'h1004, 4'h0, 4'hF, 32'h0, 32'h1122_3344);
        step();
        op(0, 32'h1004, 4'hF, 4'h0, 32'h1122_3344, 32'h0);
        n_checks++; if (err_a !== 1'b0)  begin n_fail++; $display("FAIL wr_rd_err: got %0h want 0", err_a); end
        n_checks++; if (cnt_a !== 16'd1) begin n_fail++; $display("FAIL wr_rd_count: got %0d want 1", cnt_a); end
        n_checks++; if (cnt_b !== 16'd0) begin n_fail++; $display("FAIL wr_rd_count_b: got %0d want 0", cnt_b); end
    endtask

    task automatic test_mismatch();
        do_reset();
        op(0, 32'h1004, 4'h0, 4'hF, 32'h0, 32'h1122_3344);
        idle();
        drive(0, 32'h1004, 4'hF, 4'h0, 32'h11FF_3344, 32'h0);
        #1;
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL mm_before_edge: got %0h want 0", err_a); end
        step();
        idle();
        n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL mm_err: got %0h want 1", err_a); end
        n_checks++; if (ch_a !== 2'd0)  begin n_fail++; $display("FAIL mm_ch: got %0d want 0", ch_a); end
        n_checks++; if (wd_a !== 3'd1)  begin n_fail++; $display("FAIL mm_word: got %0d want 1", wd_a); end
        n_checks++; if (by_a !== 3'd2)  begin n_fail++; $display("FAIL mm_byte: got %0d want 2", by_a); end
        op(1, 32'h1004, 4'hF, 4'h0, 32'h0, 32'h0);
        step();
        n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL mm_sticky: got %0h want 1", err_a); end
        n_checks++; if ({ch_a, wd_a, by_a} !== {2'd0, 3'd1, 3'd2})
            begin n_fail++; $display("FAIL mm_locator_held: got %0d/%0d/%0d want 0/1/2", ch_a, wd_a, by_a); end
        n_checks++; if (cnt_a !== 16'd2) begin n_fail++; $display("FAIL mm_count: got %0d want 2", cnt_a); end
    endtask

    task automatic test_chain();
        do_reset();
        idle();
        drive(0, 32'h1008, 4'h0, 4'h1, 32'h0, 32'h0000_00AB);
        drive(1, 32'h1008, 4'h1, 4'h0, 32'h0000_00AB, 32'h0);
        step();
        idle();
        n_checks++; if (err_a !== 1'b0)  begin n_fail++; $display("FAIL chain_pass_err: got %0h want 0", err_a); end
        n_checks++; if (cnt_a !== 16'd1) begin n_fail++; $display("FAIL chain_pass_count: got %0d want 1", cnt_a); end
        op(0, 32'h1008, 4'h1, 4'h1, 32'h0000_00AB, 32'h0000_00CD);
        n_checks++; if (err_a !== 1'b0)  begin n_fail++; $display("FAIL rd_then_wr_err: got %0h want 0", err_a); end
        op(0, 32'h1008, 4'h1, 4'h0, 32'h0000_00CD, 32'h0);
        n_checks++; if (err_a !== 1'b0)  begin n_fail++; $display("FAIL after_wr_err: got %0h want 0", err_a); end
        n_checks++; if (cnt_a !== 16'd3) begin n_fail++; $display("FAIL after_wr_count: got %0d want 3", cnt_a); end
        do_reset();
        idle();
        drive(0, 32'h1008, 4'h0, 4'h1, 32'h0, 32'h0000_00AB);
        drive(1, 32'h1008, 4'h1, 4'h0, 32'h0000_0000, 32'h0);
        step();
        idle();
        n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL chain_fail_err: got %0h want 1", err_a); end
        n_checks++; if ({ch_a, wd_a, by_a} !== {2'd1, 3'd2, 3'd0})
            begin n_fail++; $display("FAIL chain_fail_loc: got %0d/%0d/%0d want 1/2/0", ch_a, wd_a, by_a); end
    endtask

    task automatic test_priority();
        do_reset();
        idle();
        drive(0, 32'h1000, 4'h0, 4'hF, 32'h0, 32'h0);
        drive(1, 32'h100C, 4'h0, 4'hF, 32'h0, 32'h0);
        step();
        idle();
        drive(0, 32'h100C, 4'hF, 4'h0, 32'hFF00_FF00, 32'h0);
        drive(1, 32'h1000, 4'hF, 4'h0, 32'h0000_00FF, 32'h0);
        step();
        idle();
        n_checks++; if ({err_a, ch_a, wd_a, by_a} !== {1'b1, 2'd0, 3'd3, 3'd1})
            begin n_fail++; $display("FAIL prio_loc: got %0d %0d/%0d/%0d want 1 0/3/1", err_a, ch_a, wd_a, by_a); end
        n_checks++; if (cnt_a !== 16'd2) begin n_fail++; $display("FAIL prio_count: got %0d want 2", cnt_a); end
    endtask

    task automatic test_ignored();
        do_reset();
        op(0, 32'h1000, 4'hF, 4'h0, 32'hDEAD_BEEF, 32'h0);
        n_checks++; if ({err_a, cnt_a} !== 17'd0) begin n_fail++; $display("FAIL unwritten: got %0d/%0d want 0/0", err_a, cnt_a); end
        op(0, 32'h1010, 4'h0, 4'hF, 32'h0, 32'h1234_5678);
        op(0, 32'h1010, 4'hF, 4'h0, 32'h0, 32'h0);
        n_checks++; if ({err_a, cnt_a} !== 17'd0) begin n_fail++; $display("FAIL outside: got %0d/%0d want 0/0", err_a, cnt_a); end
        op(0, 32'h1002, 4'h0, 4'hF, 32'h0, 32'h5A5A_5A5A);
        op(0, 32'h1000, 4'hF, 4'h0, 32'h0, 32'h0);
        n_checks++; if ({err_a, cnt_a} !== 17'd0) begin n_fail++; $display("FAIL unaligned: got %0d/%0d want 0/0", err_a, cnt_a); end
        enable = 1'b0;
        op(0, 32'h100C, 4'h0, 4'hF, 32'h0, 32'hCAFE_F00D);
        op(0, 32'h100C, 4'hF, 4'h0, 32'h0, 32'h0);
        n_checks++; if ({err_a, cnt_a} !== 17'd0) begin n_fail++; $display("FAIL disabled: got %0d/%0d want 0/0", err_a, cnt_a); end
        enable = 1'b1;
        op(0, 32'h100C, 4'hF, 4'h0, 32'hCAFE_F00D, 32'h0);
        n_checks++; if ({err_a, cnt_a} !== {1'b0, 16'd1})
            begin n_fail++; $display("FAIL tracked_while_disabled: got %0d/%0d want 0/1", err_a, cnt_a); end
    endtask

    task automatic test_wrap();
        do_reset();
        op(0, 32'h0000_0000, 4'h0, 4'hF, 32'h0, 32'h5555_5555);
        op(0, 32'h0000_0000, 4'hF, 4'h0, 32'h5555_5554, 32'h0);
        n_checks++; if ({err_b, ch_b, wd_b, by_b} !== {1'b1, 2'd0, 3'd2, 3'd0})
            begin n_fail++; $display("FAIL wrap_loc: got %0d %0d/%0d/%0d want 1 0/2/0", err_b, ch_b, wd_b, by_b); end
        n_checks++; if (cnt_b !== 16'd1) begin n_fail++; $display("FAIL wrap_count: got %0d want 1", cnt_b); end
        n_checks++; if (err_a !== 1'b0)  begin n_fail++; $display("FAIL wrap_other_err: got %0h want 0", err_a); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        op(0, 32'h1004, 4'h0, 4'hF, 32'h0, 32'h1122_3344);
        op(0, 32'h1004, 4'hF, 4'h0, 32'h0, 32'h0);
        n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL pre_reset_err: got %0h want 1", err_a); end
        idle();
        drive(0, 32'h1004, 4'h0, 4'hF, 32'h0, 32'h9999_9999);
        reset = 1'b0;
        step();
        reset = 1'b1;
        idle();
        n_checks++; if ({err_a, ch_a, wd_a, by_a, cnt_a} !== 25'd0)
            begin n_fail++; $display("FAIL mid_reset_clear: got %0d %0d/%0d/%0d cnt %0d want all 0", err_a, ch_a, wd_a, by_a, cnt_a); end
        op(0, 32'h1004, 4'hF, 4'h0, 32'h0, 32'h0);
        n_checks++; if ({err_a, cnt_a} !== 17'd0)
            begin n_fail++; $display("FAIL mid_reset_discard: got %0d/%0d want 0/0", err_a, cnt_a); end
    endtask

    task automatic test_saturate();
        do_reset();
        op(0, 32'h1000, 4'h0, 4'hF, 32'h0, 32'h0);
        idle();
        drive(0, 32'h1000, 4'hF, 4'h0, 32'h0, 32'h0);
        drive(1, 32'h1000, 4'hF, 4'h0, 32'h0, 32'h0);
        repeat (32767) step();
        n_checks++; if (cnt_a !== 16'hFFFE) begin n_fail++; $display("FAIL sat_before: got %h want fffe", cnt_a); end
        step();
        n_checks++; if (cnt_a !== 16'hFFFF) begin n_fail++; $display("FAIL sat_clamp: got %h want ffff", cnt_a); end
        step();
        idle();
        n_checks++; if (cnt_a !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", cnt_a); end
        n_checks++; if (err_a !== 1'b0)     begin n_fail++; $display("FAIL sat_err: got %0h want 0", err_a); end
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_mismatch();
        test_chain();
        test_priority();
        test_ignored();
        test_wrap();
        test_reset_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
